axis_pkt_fifo: RTL
==================

AXIS_PKT_FIFO -- requirements
Module: axis_pkt_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, tdata width in bits (multiple of 8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, storage depth 2^ADDR_WIDTH beats.
REQ-003 SHALL have parameter ALMOST_FULL, default 2, almost_full_o threshold in free entries.
REQ-004 SHALL have parameter ALMOST_EMPTY, default 2, almost_empty_o threshold in committed entries.
REQ-005 SHALL have port clk_i, input, 1, sole clock; all logic is rising-edge.
REQ-006 SHALL have port a_rst_i, input, 1, asynchronous active-high reset.
REQ-007 SHALL have inputs s_axis_tdata_i [DATA_WIDTH], s_axis_tkeep_i [DATA_WIDTH/8], s_axis_tvalid_i, s_axis_tlast_i and s_axis_tuser_i (1 = bad packet, sampled on the tlast beat), plus output s_axis_tready_o.
REQ-008 SHALL have outputs m_axis_tdata_o [DATA_WIDTH], m_axis_tkeep_o [DATA_WIDTH/8], m_axis_tvalid_o and m_axis_tlast_o, plus input m_axis_tready_i.
REQ-009 SHALL have outputs full_o, almost_full_o, empty_o and almost_empty_o (1 each), pkt_cnt_o [ADDR_WIDTH+1] (committed packets held) and drop_cnt_o [16] (dropped packets, saturating).

Function
REQ-010 Each entry SHALL store {tlast, tkeep, tdata}; a beat is accepted when s_axis_tvalid_i and s_axis_tready_o are both high.
REQ-011 Write side SHALL keep a speculative pointer wr_ptr and a committed pointer wr_cmt; read side SHALL keep rd_ptr; all pointers are ADDR_WIDTH+1 bits and wrap modulo 2^(ADDR_WIDTH+1).
REQ-012 An accepted tlast beat with tuser=0 SHALL set wr_cmt to the post-write wr_ptr on the same edge and increment pkt_cnt_o.
REQ-013 An accepted tlast beat with tuser=1 SHALL set wr_ptr back to wr_cmt, write nothing visible and increment drop_cnt_o (saturating at 0xFFFF).
REQ-014 The write FSM SHALL have states ACCEPT and DROP; ACCEPT->DROP when a non-tlast beat is accepted while (wr_ptr - rd_ptr) equals 2^ADDR_WIDTH - 1 (the packet exceeds the remaining space).
REQ-015 In DROP, s_axis_tready_o SHALL be 1 and beats are discarded; on the accepted tlast beat, wr_ptr SHALL be set to wr_cmt, drop_cnt_o incremented, and the FSM returned to ACCEPT.
REQ-016 In ACCEPT, s_axis_tready_o SHALL equal !full_o; full_o = ((wr_ptr - rd_ptr) == 2^ADDR_WIDTH).
REQ-017 almost_full_o SHALL be high when (wr_ptr - rd_ptr) >= 2^ADDR_WIDTH - ALMOST_FULL.
REQ-018 The read side SHALL see only committed data: empty_o = (wr_cmt == rd_ptr), and almost_empty_o = ((wr_cmt - rd_ptr) <= ALMOST_EMPTY).
REQ-019 The output SHALL be registered first-word-fall-through: m_axis_tvalid_o rises on the second rising edge after the commit edge when the output stage is empty, and m_axis_* is held stable while tvalid=1 and tready=0.
REQ-020 Back-to-back reads SHALL sustain one beat per cycle while committed data remains.
REQ-021 An m_axis handshake with tlast=1 SHALL decrement pkt_cnt_o; if a commit occurs on the same edge, pkt_cnt_o SHALL be unchanged.
REQ-022 A simultaneous write, rollback or commit and read SHALL all take effect on the same edge with no lost or duplicated beat.

Reset
REQ-023 Asserting a_rst_i SHALL immediately zero all pointers, pkt_cnt_o, drop_cnt_o, m_axis_tvalid_o, m_axis_tlast_o and full_o/almost_full_o, set empty_o=1 and almost_empty_o=1, and put the FSM in ACCEPT.
REQ-024 s_axis_tready_o SHALL be 0 during reset and 1 from the first edge after deassertion.
REQ-025 Reset mid-packet SHALL discard every uncommitted and committed beat; RAM contents need not be cleared.

Structure
REQ-026 Package axis_pkt_fifo_pkg SHALL hold the write FSM state enum (ACCEPT, DROP) and the drop-counter width constant (16).
REQ-027 Storage SHALL be one sub-module sdp_ram, a simple dual-port RAM with registered read, width DATA_WIDTH+DATA_WIDTH/8+1 and depth 2^ADDR_WIDTH.

Verification (DATA_WIDTH=32, ADDR_WIDTH=4)
REQ-028 Send a 3-beat packet 0x11,0x22,0x33 with tuser=0 and tready=1 -> m_axis shows 0x11,0x22,0x33 with tlast on 0x33, and pkt_cnt_o goes 1 then 0.
REQ-029 Send a 4-beat packet with tuser=1 on tlast, then a 2-beat good packet 0xA,0xB -> only 0xA,0xB is output, drop_cnt_o=1 and empty_o is never low during the bad packet.
REQ-030 Send a 20-beat packet into an empty FIFO -> FSM enters DROP at beat 16, s_axis_tready_o stays 1, nothing is output, drop_cnt_o=1 and full_o then returns to 0.
REQ-031 Hold m_axis_tready_i=0 and send 16 single-beat packets -> full_o=1 and s_axis_tready_o=0 after 16 beats, almost_full_o asserts at 14; release tready -> 16 beats are output in order.
REQ-032 Assert a_rst_i for 1 cycle mid-way through beat 2 of a 5-beat packet with 1 committed packet held -> all flags return to reset values and no m_axis beat is output afterwards.

Source files
------------

// File: rtl/axis_pkt_fifo_pkg.sv
// Shared types and constants for the AXI-Stream packet FIFO.
package axis_pkt_fifo_pkg;

  // Write-side packet state: storing beats normally, or discarding an oversize packet.
  typedef enum logic {
    ACCEPT = 1'b0,
    DROP   = 1'b1
  } wr_state_t;

  // Width of the dropped-packet counter.
  localparam int DROP_CNT_W = 16;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (v == '1) ? v : v + DROP_CNT_W'(1);
  endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered,
// enable-gated read so the read data holds while the consumer stalls.
module sdp_ram
  import axis_pkt_fifo_pkg::*;
#(
  parameter int WIDTH      = 37,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data
);

  logic [WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read port; output only changes when a new read is issued.
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/axis_pkt_fifo.sv
// Store-and-forward AXI-Stream packet FIFO. Beats are written speculatively
// and only become visible to the reader once the packet's last beat arrives
// without an error flag; bad or oversize packets are rolled back and counted.
// The read side is a two-stage prefetch (RAM register + output register).
module axis_pkt_fifo
  import axis_pkt_fifo_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 8,
  parameter int ALMOST_FULL  = 2,
  parameter int ALMOST_EMPTY = 2
) (
  input  logic                    clk_i,
  input  logic                    a_rst_i,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata_i,
  input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep_i,
  input  logic                    s_axis_tvalid_i,
  input  logic                    s_axis_tlast_i,
  input  logic                    s_axis_tuser_i,
  output logic                    s_axis_tready_o,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata_o,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep_o,
  output logic                    m_axis_tvalid_o,
  output logic                    m_axis_tlast_o,
  input  logic                    m_axis_tready_i,
  output logic                    full_o,
  output logic                    almost_full_o,
  output logic                    empty_o,
  output logic                    almost_empty_o,
  output logic [ADDR_WIDTH:0]     pkt_cnt_o,
  output logic [DROP_CNT_W-1:0]   drop_cnt_o
);

  localparam int KW = DATA_WIDTH / 8;
  localparam int EW = DATA_WIDTH + KW + 1;
  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] ONE      = PW'(1);
  localparam logic [PW-1:0] DEPTH    = PW'(2**ADDR_WIDTH);
  localparam logic [PW-1:0] DEPTH_M1 = DEPTH - ONE;
  localparam logic [PW-1:0] AF_LVL   = DEPTH - PW'(ALMOST_FULL);
  localparam logic [PW-1:0] AE_LVL   = PW'(ALMOST_EMPTY);

  wr_state_t             state_reg;
  logic                  rst_done_reg;
  logic [PW-1:0]         wr_ptr_reg, wr_cmt_reg, rd_ptr_reg, pf_ptr_reg;
  logic [PW-1:0]         pkt_cnt_reg;
  logic [DROP_CNT_W-1:0] drop_cnt_reg;
  logic                  ram_vld_reg, m_valid_reg, m_last_reg;
  logic [DATA_WIDTH-1:0] m_data_reg;
  logic [KW-1:0]         m_keep_reg;
  logic [EW-1:0]         ram_rd_data;

  logic [PW-1:0] used, committed;
  logic          full, s_ready, s_acc, wr_en, commit;
  logic          m_hs, pkt_done, out_ready, rd_en;

  // Occupancy counts everything not yet handed out, including speculative beats
  // and beats sitting in the output pipeline.
  assign used      = wr_ptr_reg - rd_ptr_reg;
  assign committed = wr_cmt_reg - rd_ptr_reg;
  assign full      = (used == DEPTH);

  assign s_ready = rst_done_reg && ((state_reg == DROP) || !full);
  assign s_acc   = s_axis_tvalid_i && s_ready;
  assign wr_en   = s_acc && (state_reg == ACCEPT);
  assign commit  = wr_en && s_axis_tlast_i && !s_axis_tuser_i;

  assign m_hs      = m_valid_reg && m_axis_tready_i;
  assign pkt_done  = m_hs && m_last_reg;
  assign out_ready = !m_valid_reg || m_axis_tready_i;
  // Prefetch a committed beat whenever the RAM register is free or draining.
  assign rd_en     = (pf_ptr_reg != wr_cmt_reg) && (!ram_vld_reg || out_ready);

  sdp_ram #(
    .WIDTH      (EW),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk_i),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_reg[ADDR_WIDTH-1:0]),
    .wr_data ({s_axis_tlast_i, s_axis_tkeep_i, s_axis_tdata_i}),
    .rd_en   (rd_en),
    .rd_addr (pf_ptr_reg[ADDR_WIDTH-1:0]),
    .rd_data (ram_rd_data)
  );

  // Write FSM: speculative write, commit on good tlast, rollback on bad or oversize packet.
  always_ff @(posedge clk_i or posedge a_rst_i) begin
    if (a_rst_i) begin
      state_reg    <= ACCEPT;
      rst_done_reg <= 1'b0;
      wr_ptr_reg   <= '0;
      wr_cmt_reg   <= '0;
      drop_cnt_reg <= '0;
    end else begin
      rst_done_reg <= 1'b1;
      if (s_acc) begin
        case (state_reg)
          ACCEPT: begin
            if (s_axis_tlast_i) begin
              if (s_axis_tuser_i) begin
                wr_ptr_reg   <= wr_cmt_reg;
                drop_cnt_reg <= sat_inc(drop_cnt_reg);
              end else begin
                wr_ptr_reg <= wr_ptr_reg + ONE;
                wr_cmt_reg <= wr_ptr_reg + ONE;
              end
            end else begin
              wr_ptr_reg <= wr_ptr_reg + ONE;
              // This beat fills the last slot and the packet still continues.
              if (used == DEPTH_M1) state_reg <= DROP;
            end
          end
          DROP: begin
            if (s_axis_tlast_i) begin
              wr_ptr_reg   <= wr_cmt_reg;
              drop_cnt_reg <= sat_inc(drop_cnt_reg);
              state_reg    <= ACCEPT;
            end
          end
          default: state_reg <= ACCEPT;
        endcase
      end
    end
  end

  // Committed-packet counter: +1 on commit, -1 when a packet's last beat leaves.
  always_ff @(posedge clk_i or posedge a_rst_i) begin
    if (a_rst_i) begin
      pkt_cnt_reg <= '0;
    end else if (commit && !pkt_done) begin
      pkt_cnt_reg <= pkt_cnt_reg + ONE;
    end else if (!commit && pkt_done) begin
      pkt_cnt_reg <= pkt_cnt_reg - ONE;
    end
  end

  // Read pipeline: RAM register feeds the output register; rd_ptr frees space on handshake.
  always_ff @(posedge clk_i or posedge a_rst_i) begin
    if (a_rst_i) begin
      rd_ptr_reg  <= '0;
      pf_ptr_reg  <= '0;
      ram_vld_reg <= 1'b0;
      m_valid_reg <= 1'b0;
      m_last_reg  <= 1'b0;
      m_keep_reg  <= '0;
      m_data_reg  <= '0;
    end else begin
      if (m_hs)  rd_ptr_reg <= rd_ptr_reg + ONE;
      if (rd_en) pf_ptr_reg <= pf_ptr_reg + ONE;
      if (rd_en) ram_vld_reg <= 1'b1;
      else if (out_ready) ram_vld_reg <= 1'b0;
      if (out_ready) begin
        m_valid_reg <= ram_vld_reg;
        if (ram_vld_reg) {m_last_reg, m_keep_reg, m_data_reg} <= ram_rd_data;
      end
    end
  end

  assign s_axis_tready_o = s_ready;
  assign m_axis_tdata_o  = m_data_reg;
  assign m_axis_tkeep_o  = m_keep_reg;
  assign m_axis_tvalid_o = m_valid_reg;
  assign m_axis_tlast_o  = m_last_reg;
  assign full_o          = full;
  assign almost_full_o   = (used >= AF_LVL);
  assign empty_o         = (wr_cmt_reg == rd_ptr_reg);
  assign almost_empty_o  = (committed <= AE_LVL);
  assign pkt_cnt_o       = pkt_cnt_reg;
  assign drop_cnt_o      = drop_cnt_reg;

endmodule
